// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative fp32 multiplier.
package fp_pkg;

   // Rounding modes; encodings 101-111 fall back to RNE where decoded.
   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } r_mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_ROUND,
      S_DONE
   } state_e;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = FRAC_W + 1;
   localparam int PROD_W = 2 * MANT_W;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] INF_MAG  = 32'h7F80_0000;
   localparam logic [31:0] MAXF_MAG = 32'h7F7F_FFFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_round_norm.sv
// Normalizes the exact 48-bit mantissa product, rounds it and packs the fp32
// result together with the overflow/underflow flags.
module fp_round_norm
   import fp_pkg::*;
(
   input  logic [PROD_W-1:0] prod,
   input  logic signed [9:0] exp_pre,
   input  logic              sign,
   input  logic [2:0]        r_mode,
   output logic [31:0]       z,
   output logic              ovrf,
   output logic              udrf
);

   logic              top;
   logic [MANT_W-1:0] mant;
   logic              guard;
   logic              sticky;
   logic              inc;
   logic              carry;
   logic              unused_hidden;
   logic [FRAC_W-1:0] frac;
   logic signed [9:0] e_norm;
   logic signed [9:0] e_fin;

   // Normalize, round, then classify the rounded exponent.
   // NOTE: every output gets a default at the top of the block so no path
   // through the case statements can leave a latch behind.
   always_comb begin
      z    = '0;
      ovrf = 1'b0;
      udrf = 1'b0;
      inc  = 1'b0;

      // A product of two 1.x mantissas lies in [1,4): bit 47 selects the scale.
      top = prod[PROD_W-1];
      if (top) begin
         mant   = prod[47:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         mant   = prod[46:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      e_norm = exp_pre + $signed({9'b0, top});

      case (r_mode)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | mant[0]);
      endcase

      // On a carry-out the mantissa becomes exactly 1.0, so the fraction
      // bits below the hidden bit are already zero.
      {carry, unused_hidden, frac} = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
      e_fin = e_norm + $signed({9'b0, carry});

      if (e_fin >= 10'sd255) begin
         ovrf = 1'b1;
         case (r_mode)
            RM_RTZ:  z = {sign, MAXF_MAG[30:0]};
            RM_RDN:  z = sign ? {sign, INF_MAG[30:0]} : {sign, MAXF_MAG[30:0]};
            RM_RUP:  z = sign ? {sign, MAXF_MAG[30:0]} : {sign, INF_MAG[30:0]};
            default: z = {sign, INF_MAG[30:0]};
         endcase
      end else if (e_fin <= 10'sd0) begin
         udrf = 1'b1;
         z    = {sign, 31'b0};
      end else begin
         z = {sign, e_fin[7:0], frac};
      end
   end

endmodule

// File: rtl/fp_mul_iter.sv
// Sequential fp32 multiplier: radix-2^BITS_PER_CYCLE shift-add mantissa
// datapath, one rounding cycle, valid/ready handshakes on both sides.
module fp_mul_iter
   import fp_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1,  // legal: 1, 2, 3, 4, 6, 8, 12, 24
   parameter int MUL_STEPS      = 24 / BITS_PER_CYCLE
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       fp_X,
   input  logic [31:0]       fp_Y,
   input  logic [2:0]        r_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       fp_Z,
   output logic              ovrf,
   output logic              udrf,
   output logic [PROD_W-1:0] frc_Z_full,
   output logic [FRAC_W-1:0] frc_X,
   output logic [FRAC_W-1:0] frc_Y
);

   localparam logic [4:0] CNT_LAST = 5'(MUL_STEPS - 1);

   state_e              state;
   fp32_t               x_in;
   fp32_t               y_in;
   logic                in_sign;
   logic                x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
   logic                spec_hit;
   logic [31:0]         spec_z;

   logic [PROD_W-1:0]   mcand_sh;   // 1.fX, pre-shifted to the current digit weight
   logic [MANT_W-1:0]   mplier;     // remaining digits of 1.fY, LSB first
   logic [4:0]          cnt;
   logic                sign_q;
   logic [2:0]          r_mode_q;
   logic signed [9:0]   exp_pre;
   logic [PROD_W-1:0]   digit_ext;
   logic [PROD_W-1:0]   pp;

   logic [31:0]         rn_z;
   logic                rn_ovrf;
   logic                rn_udrf;

   assign x_in    = fp_X;
   assign y_in    = fp_Y;
   assign in_sign = x_in.sign ^ y_in.sign;

   // Accept only from IDLE and never while reset is asserted.
   assign in_ready = (state == S_IDLE) && !rst;

   // Operand classification and the result for special operands.
   always_comb begin
      x_nan  = (x_in.exp == 8'hFF) && (x_in.frac != '0);
      y_nan  = (y_in.exp == 8'hFF) && (y_in.frac != '0);
      x_inf  = (x_in.exp == 8'hFF) && (x_in.frac == '0);
      y_inf  = (y_in.exp == 8'hFF) && (y_in.frac == '0);
      // Denormals flush to zero, so an exponent field of 0 means zero.
      x_zero = (x_in.exp == '0);
      y_zero = (y_in.exp == '0);

      spec_hit = 1'b1;
      if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
         spec_z = QNAN;
      else if (x_inf || y_inf)
         spec_z = {in_sign, INF_MAG[30:0]};
      else if (x_zero || y_zero)
         spec_z = {in_sign, 31'b0};
      else begin
         spec_hit = 1'b0;
         spec_z   = '0;
      end
   end

   // Partial product for the current multiplier digit.
   always_comb begin
      digit_ext = {{(PROD_W-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
      pp        = mcand_sh * digit_ext;
   end

   fp_round_norm u_round (
      .prod    (frc_Z_full),
      .exp_pre (exp_pre),
      .sign    (sign_q),
      .r_mode  (r_mode_q),
      .z       (rn_z),
      .ovrf    (rn_ovrf),
      .udrf    (rn_udrf)
   );

   // Control FSM with the iteration datapath and registered outputs.
   // NOTE: state is updated with non-blocking assignments only, so every
   // register in this block samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         fp_Z       <= '0;
         ovrf       <= 1'b0;
         udrf       <= 1'b0;
         out_valid  <= 1'b0;
         frc_Z_full <= '0;
         frc_X      <= '0;
         frc_Y      <= '0;
         mcand_sh   <= '0;
         mplier     <= '0;
         cnt        <= '0;
         sign_q     <= 1'b0;
         r_mode_q   <= '0;
         exp_pre    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  frc_X      <= x_in.frac;
                  frc_Y      <= y_in.frac;
                  sign_q     <= in_sign;
                  r_mode_q   <= r_mode;
                  exp_pre    <= $signed({2'b00, x_in.exp}) + $signed({2'b00, y_in.exp})
                                - 10'(BIAS);
                  frc_Z_full <= '0;
                  mcand_sh   <= {{MANT_W{1'b0}}, 1'b1, x_in.frac};
                  mplier     <= {1'b1, y_in.frac};
                  cnt        <= '0;
                  if (spec_hit) begin
                     fp_Z      <= spec_z;
                     ovrf      <= 1'b0;
                     udrf      <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     state <= S_MUL;
                  end
               end
            end
            S_MUL: begin
               frc_Z_full <= frc_Z_full + pp;
               mcand_sh   <= mcand_sh << BITS_PER_CYCLE;
               mplier     <= mplier >> BITS_PER_CYCLE;
               cnt        <= cnt + 5'd1;
               if (cnt == CNT_LAST)
                  state <= S_ROUND;
            end
            S_ROUND: begin
               fp_Z      <= rn_z;
               ovrf      <= rn_ovrf;
               udrf      <= rn_udrf;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
